// File: rtl/ext_32.sv
// Registered immediate-extension stage: widens a decode-stage immediate to an
// ALU/branch operand (sign, zero, upper placement or branch word offset).
module ext_32 #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       ext_op,
    input  logic [IN_W-1:0]  imm_16,
    output logic [OUT_W-1:0] Imm_32,
    output logic             out_valid
);

    localparam int unsigned FILL_W = OUT_W - IN_W;

    typedef enum logic [1:0] {
        OP_SIGN   = 2'b00,
        OP_ZERO   = 2'b01,
        OP_UPPER  = 2'b10,
        OP_BRANCH = 2'b11
    } ext_op_e;

    logic             sign_c;
    logic [OUT_W-1:0] sext_c;
    logic [OUT_W-1:0] zext_c;
    logic [OUT_W-1:0] upper_c;
    logic [OUT_W-1:0] branch_c;
    logic [OUT_W-1:0] ext_c;

    // Candidate results for every mode; the op selects one.
    always_comb begin
        sign_c   = imm_16[IN_W-1];
        sext_c   = {{FILL_W{sign_c}}, imm_16};
        zext_c   = {{FILL_W{1'b0}}, imm_16};
        upper_c  = {imm_16, {FILL_W{1'b0}}};
        // Branch offsets are word counts: scale to a byte offset, dropping the top bits.
        branch_c = sext_c << 2;
        ext_c    = sext_c;
        case (ext_op_e'(ext_op))
            OP_SIGN:   ext_c = sext_c;
            OP_ZERO:   ext_c = zext_c;
            OP_UPPER:  ext_c = upper_c;
            OP_BRANCH: ext_c = branch_c;
            default:   ext_c = sext_c;
        endcase
    end

    // Result only loads on valid cycles, so idle-cycle garbage on imm_16/ext_op never lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            Imm_32    <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Imm_32 <= ext_c;
            end
        end
    end

endmodule

// File: tb/tb_ext_32.sv
// Directed and randomized checks of ext_32 against an arithmetic reference model.
module tb_ext_32;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [1:0]  ext_op;
    logic [15:0] imm_16;
    logic [31:0] Imm_32;
    logic        out_valid;

    int vectors;
    int miscompares;

    logic [31:0] exp_imm;
    logic        exp_valid;

    ext_32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .ext_op    (ext_op),
        .imm_16    (imm_16),
        .Imm_32    (Imm_32),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: treat the immediate as a number and do plain arithmetic.
    function automatic logic [31:0] ref_f(input logic [1:0] op, input logic [15:0] imm);
        int s;
        int u;
        s = int'($signed(imm));
        u = int'(imm);
        case (op)
            2'd0:    return 32'(s);
            2'd1:    return 32'(u);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, and compare both outputs after the edge.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [1:0] op, input logic [15:0] imm);
        rst      = r;
        in_valid = v;
        ext_op   = op;
        imm_16   = imm;
        if (r) begin
            exp_imm   = 32'h0;
            exp_valid = 1'b0;
        end else if (v) begin
            exp_imm   = ref_f(op, imm);
            exp_valid = 1'b1;
        end else begin
            exp_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check({tag, ".imm"}, Imm_32, exp_imm);
        check({tag, ".vld"}, {31'b0, out_valid}, {31'b0, exp_valid});
    endtask

    task automatic expect_val(input string tag, input logic [31:0 ] want);
        check(tag, Imm_32, want);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_imm     = 32'h0;
        exp_valid   = 1'b0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        ext_op      = 2'd0;
        imm_16      = 16'h0;

        step("rst0", 1'b1, 1'b0, 2'd0, 16'h0);
        step("rst1", 1'b1, 1'b1, 2'd0, 16'h1234);

        // Sign-extend positives
        step("sx0",  1'b0, 1'b1, 2'd0, 16'd0);   expect_val("sx0.k",  32'h0000_0000);
        step("sx4",  1'b0, 1'b1, 2'd0, 16'd4);   expect_val("sx4.k",  32'h0000_0004);
        step("sx23", 1'b0, 1'b1, 2'd0, 16'd23);  expect_val("sx23.k", 32'h0000_0017);

        // Sign-extend negatives and boundaries
        step("sxm3",  1'b0, 1'b1, 2'd0, 16'hFFFD); expect_val("sxm3.k",  32'hFFFF_FFFD);
        step("sxm25", 1'b0, 1'b1, 2'd0, 16'hFFE7); expect_val("sxm25.k", 32'hFFFF_FFE7);
        step("sxmin", 1'b0, 1'b1, 2'd0, 16'h8000); expect_val("sxmin.k", 32'hFFFF_8000);
        step("sxmax", 1'b0, 1'b1, 2'd0, 16'h7FFF); expect_val("sxmax.k", 32'h0000_7FFF);

        // Other modes
        step("zx",   1'b0, 1'b1, 2'd1, 16'hFFFD); expect_val("zx.k",   32'h0000_FFFD);
        step("up",   1'b0, 1'b1, 2'd2, 16'hFFFD); expect_val("up.k",   32'hFFFD_0000);
        step("brn",  1'b0, 1'b1, 2'd3, 16'hFFFD); expect_val("brn.k",  32'hFFFF_FFF4);
        step("brp",  1'b0, 1'b1, 2'd3, 16'h0005); expect_val("brp.k",  32'h0000_0014);
        step("up2",  1'b0, 1'b1, 2'd2, 16'h1234); expect_val("up2.k",  32'h1234_0000);

        // Hold while idle with toggling inputs
        step("cap",   1'b0, 1'b1, 2'd0, 16'h0017);
        step("hold0", 1'b0, 1'b0, 2'd2, 16'hFFFF); expect_val("hold0.k", 32'h0000_0017);
        step("hold1", 1'b0, 1'b0, 2'd3, 16'h8000); expect_val("hold1.k", 32'h0000_0017);
        step("hold2", 1'b0, 1'b0, 2'd1, 16'h5A5A); expect_val("hold2.k", 32'h0000_0017);

        // Reset mid-stream discards the in-flight value
        step("pre",   1'b0, 1'b1, 2'd1, 16'hABCD);
        step("rstm",  1'b1, 1'b1, 2'd0, 16'hFFFF); expect_val("rstm.k", 32'h0000_0000);
        step("post",  1'b0, 1'b1, 2'd3, 16'h0001); expect_val("post.k", 32'h0000_0004);

        // Randomized stream with occasional idle cycles and resets
        for (int i = 0; i < 300; i++) begin
            logic       r;
            logic       v;
            logic [1:0] op;
            logic [15:0] imm;
            r   = ($urandom_range(0, 31) == 0);
            v   = ($urandom_range(0, 3) != 0);
            op  = 2'($urandom_range(0, 3));
            imm = 16'($urandom);
            step("rnd", r, v, op, imm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
